frame_dispatcher: RTL and testbench
===================================

# frame_dispatcher

Sequencer that streams a granted task's instruction frames from task memory onto the 16-bit core bus. It addresses a synchronous single-port task RAM word by word and presents each word to the cores selected by a core mask. It advances only once every selected core has acknowledged via `core_reading`. It sits between the `scheduler` grant logic, which supplies start frame, frame count and core mask, and the per-core instruction loaders.

## Interface
- `DATA_DEPTH`, 1024: task memory depth in 16-bit words; address width is $clog2(DATA_DEPTH).
- `INSTR_SIZE`, 16: word and bus width in bits.
- `FRAME_SIZE`, 256: frame size in bits. WORDS_PER_FRAME = FRAME_SIZE/INSTR_SIZE = 16.
- `FRAME_NUM`, 64: frames in memory; frame index width is $clog2(FRAME_NUM).
- `CORE_NUM`, 16: number of cores and mask width.
- `TIMEOUT_CYCLES`, 255: acknowledge timeout. Used only with `DISPATCH_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: dispatch request, sampled only in IDLE.
- `start_frame` in 6: first frame index.
- `frame_cnt` in 6: number of frames; 0 means FRAME_NUM (64).
- `core_mask` in 16: destination cores, latched at start.
- `abort` in 1: synchronous cancel.
- `mem_rd` out 1: task RAM read strobe.
- `mem_addr` out 10: task RAM word address.
- `mem_rdata` in 16: RAM data, valid on the edge after the `mem_rd` edge.
- `bus_data` out 16: word to cores.
- `bus_valid` out 1: `bus_data` valid.
- `bus_core_sel` out 16: latched mask, 0 when idle.
- `core_reading` in 16: per-core acknowledge.
- `frame_being_sent` out 1: high in RD/WAIT/SEND.
- `frame_end` out 1: 1-cycle pulse when the last word of a frame is accepted.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: 1-cycle pulse when the task completes.
- `err` out 1: timeout flag, sticky until the next accepted `start`. Tied 0 without the macro.

## Operation
- States: IDLE, RD, WAIT, SEND, DONE.
- **IDLE:**
  - `start` = 1 latches the mask, the word address = start_frame*16, and remaining words = frame_cnt*16 (with 0 meaning 1024).
  - It clears `err` and moves to RD.
  - `start` = 1 with `core_mask` = 0 goes straight to DONE and no words are sent.
- **RD:** assert `mem_rd` for one cycle with the current address, then go to WAIT.
- **WAIT:** capture `mem_rdata` into `bus_data`, set `bus_valid`, then go to SEND.
- **SEND:**
  - A word is accepted when `(core_reading & bus_core_sel) == bus_core_sel`.
  - On accept:
    - clear `bus_valid`;
    - increment the address modulo DATA_DEPTH, so wrap 1023→0;
    - decrement the remaining-word count;
    - pulse `frame_end` if the address low 4 bits were 15.
  - If the remaining count reaches 0, go to DONE; otherwise go to RD.
  - Unselected cores' `core_reading` bits are ignored.
- **DONE:** pulse `done`, return to IDLE.
- `start` outside IDLE is ignored. `start` in the DONE cycle is also ignored.
- **Abort:**
  - `abort` in any non-IDLE state goes to IDLE on the next edge.
  - It clears `bus_valid` and `bus_core_sel`, asserts no `done`, and leaves `err` unchanged.
  - Abort has priority over accept in the same cycle.
- **Reset values:** all outputs 0, state IDLE, counters 0. Reset mid-task discards the task.

## Timing
- `start` sampled at edge N:
  - `mem_rd` = 1 during N..N+1;
  - `bus_valid` = 1 from edge N+2.
- Per word: 3 cycles minimum (RD, WAIT, SEND with immediate acknowledge).
- A full 16-word frame takes at least 48 cycles.
- `done` is asserted 1 cycle after the last accept.
- `bus_data` and `bus_core_sel` are stable while `bus_valid` = 1.
- All outputs are registered.

## Configuration
- `DISPATCH_TIMEOUT_EN` defined:
  - a counter runs in SEND and resets on each accept;
  - when it reaches `TIMEOUT_CYCLES` without an accept, set `err`, pulse `done`, and return to IDLE through DONE.
- `DISPATCH_TIMEOUT_EN` undefined: no counter is built, SEND waits indefinitely, and `err` is tied to 0.

## Structure
- Shared package `gpu_sched_pkg` holds:
  - the WORDS_PER_FRAME, FRAME_IDX_W and MEM_ADDR_W constants;
  - the dispatcher state enum typedef;
  - the core-mask typedef, which is also used by `scheduler`.
- One sub-module, `frame_addr_gen`, holds:
  - the word address register with wrap;
  - the remaining-word down-counter;
  - the `frame_end` and last-word decode.

## Test plan
- **Single frame, immediate ack:**
  - Stimulus: start_frame = 0, frame_cnt = 1, core_mask = 16'h000f, core_reading = 16'hffff.
  - Response: 16 words sent from addresses 0..15 at 3 cycles each; `frame_end` once; `done` at cycle 49 after start.
- **Partial ack:**
  - Stimulus: mask 16'h00f0, core_reading = 16'h0070 for 10 cycles, then 16'h00f0.
  - Response: the first word is held for 10 cycles with stable `bus_data`, then accepted.
- **Wrap-around:**
  - Stimulus: start_frame = 63, frame_cnt = 2.
  - Response: addresses 1008..1023 then 0..15; two `frame_end` pulses; then `done`.
- **frame_cnt = 0 and mask = 0:**
  - frame_cnt = 0 sends 1024 words.
  - mask = 0 pulses `done` 1 cycle after start with `bus_valid` never high.
- **Abort and start-while-busy:**
  - Stimulus: abort asserted during the 5th word's SEND, with a `start` pulse issued mid-task.
  - Response: returns to IDLE next cycle; no `done`; the mid-task `start` is ignored.
- **Timeout (`DISPATCH_TIMEOUT_EN`, TIMEOUT_CYCLES = 20):**
  - Stimulus: core_reading = 0.
  - Response: `err` = 1 and `done` pulses 20 cycles into the first SEND; `err` clears on the next start.

Source files
------------

// File: rtl/gpu_sched_pkg.sv
// Shared scheduler/dispatcher types and constants.
// Holds frame geometry, dispatcher states and the core-mask type.
package gpu_sched_pkg;

  localparam int WORDS_PER_FRAME = 16;
  localparam int WORD_IDX_W      = 4;
  localparam int FRAME_IDX_W     = 6;
  localparam int MEM_ADDR_W      = 10;
  localparam int MASK_W          = 16;

  typedef logic [MASK_W-1:0] core_mask_t;

  typedef enum logic [2:0] {
    DS_IDLE,
    DS_RD,
    DS_WAIT,
    DS_SEND,
    DS_DONE
  } disp_state_t;

endpackage

// File: rtl/frame_dispatcher_addr_gen.sv
// Task RAM word address with wrap and remaining-word down-counter.
// Decodes the last word of the task and the last word of a frame.
module frame_addr_gen
  import gpu_sched_pkg::*;
#(
  parameter int AW = MEM_ADDR_W,
  parameter int FW = FRAME_IDX_W,
  parameter int WW = WORD_IDX_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          advance,
  input  logic [FW-1:0] start_frame,
  input  logic [FW-1:0] frame_cnt,
  output logic [AW-1:0] addr,
  output logic          last_word,
  output logic          frame_last
);

  logic [AW:0] rem;

  // frame_cnt of zero sets the top bit alone: a full-memory task
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      rem  <= '0;
    end else if (load) begin
      addr <= {start_frame, {WW{1'b0}}};
      rem  <= {frame_cnt == '0, frame_cnt, {WW{1'b0}}};
    end else if (advance) begin
      addr <= addr + 1'b1;
      rem  <= rem - 1'b1;
    end
  end

  assign last_word  = rem == (AW+1)'(1);
  assign frame_last = &addr[WW-1:0];

endmodule

// File: rtl/frame_dispatcher.sv
// Streams task frames from task RAM onto the core bus.
// DISPATCH_TIMEOUT_EN adds an acknowledge timeout that sets err.
module frame_dispatcher
  import gpu_sched_pkg::*;
#(
  parameter int DATA_DEPTH     = 1024,
  parameter int INSTR_SIZE     = 16,
  parameter int FRAME_SIZE     = 256,
  parameter int FRAME_NUM      = 64,
  parameter int CORE_NUM       = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(FRAME_NUM)-1:0]  start_frame,
  input  logic [$clog2(FRAME_NUM)-1:0]  frame_cnt,
  input  logic [CORE_NUM-1:0]           core_mask,
  input  logic                          abort,
  output logic                          mem_rd,
  output logic [$clog2(DATA_DEPTH)-1:0] mem_addr,
  input  logic [INSTR_SIZE-1:0]         mem_rdata,
  output logic [INSTR_SIZE-1:0]         bus_data,
  output logic                          bus_valid,
  output logic [CORE_NUM-1:0]           bus_core_sel,
  input  logic [CORE_NUM-1:0]           core_reading,
  output logic                          frame_being_sent,
  output logic                          frame_end,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int FW = $clog2(FRAME_NUM);
  localparam int WW = $clog2(FRAME_SIZE / INSTR_SIZE);

  disp_state_t state, state_d;
  logic load, accept, advance, timeout;
  logic last_word, frame_last;

  frame_addr_gen #(
    .AW(AW),
    .FW(FW),
    .WW(WW)
  ) u_addr (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .advance    (advance),
    .start_frame(start_frame),
    .frame_cnt  (frame_cnt),
    .addr       (mem_addr),
    .last_word  (last_word),
    .frame_last (frame_last)
  );

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != DS_SEND || accept)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state == DS_SEND) && !accept &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if (load)
      err <= 1'b0;
    else if (timeout && !abort)
      err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    load    = (state == DS_IDLE) && start;
    accept  = (state == DS_SEND) &&
              ((core_reading & bus_core_sel) == bus_core_sel);
    advance = accept && !abort;
    state_d = state;
    unique case (state)
      DS_IDLE: if (start)
                 state_d = (core_mask == '0) ? DS_DONE : DS_RD;
      DS_RD:   state_d = DS_WAIT;
      DS_WAIT: state_d = DS_SEND;
      DS_SEND: if (accept)
                 state_d = last_word ? DS_DONE : DS_RD;
               else if (timeout)
                 state_d = DS_DONE;
      DS_DONE: state_d = DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
    // abort wins over accept and timeout
    if (abort && state != DS_IDLE)
      state_d = DS_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= DS_IDLE;
      mem_rd           <= 1'b0;
      bus_valid        <= 1'b0;
      bus_data         <= '0;
      bus_core_sel     <= '0;
      frame_being_sent <= 1'b0;
      frame_end        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_d;
      mem_rd           <= state_d == DS_RD;
      bus_valid        <= state_d == DS_SEND;
      frame_being_sent <= state_d inside {DS_RD, DS_WAIT, DS_SEND};
      busy             <= state_d != DS_IDLE;
      done             <= state_d == DS_DONE;
      frame_end        <= advance && frame_last;
      if (state == DS_WAIT)
        bus_data <= mem_rdata;
      if (load)
        bus_core_sel <= core_mask;
      else if (state_d == DS_IDLE)
        bus_core_sel <= '0;
    end
  end

endmodule

// File: tb/tb_frame_dispatcher.sv
// Scoreboard bench for frame_dispatcher with a RAM model.
// Timeout scenario runs only when DISPATCH_TIMEOUT_EN is defined.
module tb_frame_dispatcher;
  import gpu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [5:0]  start_frame, frame_cnt;
  logic [15:0] core_mask, core_reading;
  logic [15:0] mem_rdata, bus_data, bus_core_sel;
  logic [9:0]  mem_addr;
  logic        mem_rd, bus_valid, frame_being_sent;
  logic        frame_end, busy, done, err;

  always #5 clk = ~clk;

  frame_dispatcher #(.TIMEOUT_CYCLES(20)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .start_frame     (start_frame),
    .frame_cnt       (frame_cnt),
    .core_mask       (core_mask),
    .abort           (abort),
    .mem_rd          (mem_rd),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .bus_data        (bus_data),
    .bus_valid       (bus_valid),
    .bus_core_sel    (bus_core_sel),
    .core_reading    (core_reading),
    .frame_being_sent(frame_being_sent),
    .frame_end       (frame_end),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  logic [15:0] ram [1024];
  always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

  typedef struct {
    int          addr;
    logic [15:0] data;
    logic [15:0] mask;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int done_cnt = 0, fe_cnt = 0, words_seen = 0;
  int cyc = 0, base_done, base_fe;
  int ack_mode = 0;
  bit valid_seen;
  logic prev_valid = 1'b0;
  logic [15:0] hold_data;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the expected word each time a new word appears
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (done) done_cnt++;
      if (frame_end) fe_cnt++;
      if (bus_valid) valid_seen = 1'b1;
      if (bus_valid && !prev_valid) begin
        words_seen++;
        if (sb.size() == 0) check("unexpected_word", 1, 0);
        else begin
          e = sb.pop_front();
          check("word_addr", 32'(mem_addr), e.addr);
          check("word_data", 32'(bus_data), 32'(e.data));
          check("core_sel", 32'(bus_core_sel), 32'(e.mask));
        end
        hold_data = bus_data;
      end else if (bus_valid) begin
        check("data_stable", 32'(bus_data), 32'(hold_data));
      end
      prev_valid = bus_valid;
    end
  end

  // acknowledge driver; unselected bits are always random
  always @(negedge clk) begin
    case (ack_mode)
      1: core_reading = 16'($urandom) | bus_core_sel;
      2: core_reading = $urandom_range(0, 1) ? 16'hffff : 16'($urandom);
      default: ;
    endcase
  end

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_task(input int sf, input int fc,
                            input logic [15:0] mask);
    int n;
    int a;
    exp_t e;
    n = (fc == 0) ? 1024 : fc * 16;
    if (mask != 0)
      for (int i = 0; i < n; i++) begin
        a = (sf * 16 + i) % 1024;
        e.addr = a;
        e.data = ram[a];
        e.mask = mask;
        sb.push_back(e);
      end
    base_done = done_cnt;
    base_fe = fe_cnt;
    valid_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    start_frame = 6'(sf);
    frame_cnt = 6'(fc);
    core_mask = mask;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    tick();
    check("mem_rd_first", 32'(mem_rd), 32'(mask != 0));
  endtask

  task automatic wait_done();
    while (!done && cyc < 20000) tick();
    check("done_seen", 32'(done), 1);
  endtask

  task automatic finish_task(input int exp_cyc, input int exp_fe,
                             input int exp_left, input bit no_valid);
    if (exp_cyc >= 0) check("done_cycle", cyc, exp_cyc);
    tick();
    check("done_pulses", done_cnt - base_done, 1);
    check("frame_ends", fe_cnt - base_fe, exp_fe);
    check("sb_left", sb.size(), exp_left);
    check("idle_busy", 32'(busy), 0);
    check("idle_sel", 32'(bus_core_sel), 0);
    if (no_valid) check("valid_never", 32'(valid_seen), 0);
    sb.delete();
  endtask

  initial begin
    int sf, fc, w0;
    logic [15:0] m;
    for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    start_frame = '0;
    frame_cnt = '0;
    core_mask = '0;
    core_reading = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'({mem_rd, bus_valid, busy, done, frame_end,
                           frame_being_sent, err}), 0);
    check("rst_sel", 32'(bus_core_sel), 0);
    check("rst_data", 32'(bus_data), 0);
    reset = 1'b0;

    // single frame, immediate acknowledge
    ack_mode = 1;
    start_task(0, 1, 16'h000f);
    check("fbs_in_rd", 32'(frame_being_sent), 1);
    wait_done();
    finish_task(49, 1, 0, 1'b0);

    // partial acknowledge holds the first word
    ack_mode = 0;
    core_reading = 16'h0070;
    sf = $urandom_range(0, 63);
    start_task(sf, 1, 16'h00f0);
    while (!bus_valid && cyc < 10) tick();
    for (int i = 0; i < 10; i++) tick();
    check("held_valid", 32'(bus_valid), 1);
    check("held_addr", 32'(mem_addr), sf * 16);
    core_reading = 16'h00f0;
    ack_mode = 1;
    wait_done();
    finish_task(-1, 1, 0, 1'b0);

    // wrap from the last frame into frame 0
    start_task(63, 2, 16'h8001);
    wait_done();
    finish_task(2 * 48 + 1, 2, 0, 1'b0);

    // frame_cnt = 0 covers the whole memory
    start_task(5, 0, 16'h0100);
    wait_done();
    finish_task(1024 * 3 + 1, 64, 0, 1'b0);

    // empty mask completes without sending
    start_task(3, 2, 16'h0000);
    check("mask0_done", 32'(done), 1);
    finish_task(1, 0, 0, 1'b1);

    // abort in the 5th word, with an ignored mid-task start
    m = 16'($urandom_range(1, 65535));
    start_task(7, 1, m);
    w0 = words_seen;
    while (words_seen - w0 < 2 && cyc < 200) tick();
    start = 1'b1;
    start_frame = 6'd40;
    frame_cnt = 6'd3;
    core_mask = 16'hffff;
    tick();
    start = 1'b0;
    while (!(bus_valid && words_seen - w0 == 5) && cyc < 200) tick();
    check("abort_in_send", 32'(bus_valid), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(bus_valid), 0);
    check("abort_sel", 32'(bus_core_sel), 0);
    check("abort_fbs", 32'(frame_being_sent), 0);
    for (int i = 0; i < 10; i++) tick();
    check("abort_stay_idle", 32'(busy), 0);
    check("abort_no_done", done_cnt - base_done, 0);
    check("abort_sb_left", sb.size(), 11);
    sb.delete();

    // randomized tasks
    ack_mode = 2;
    for (int t = 0; t < 8; t++) begin
      sf = $urandom_range(0, 63);
      fc = $urandom_range(1, 3);
      m = 16'($urandom_range(1, 65535));
      start_task(sf, fc, m);
      wait_done();
      finish_task(-1, fc, 0, 1'b0);
    end

`ifdef DISPATCH_TIMEOUT_EN
    ack_mode = 0;
    core_reading = '0;
    start_task(0, 1, 16'h0003);
    wait_done();
    check("timeout_err", 32'(err), 1);
    finish_task(23, 0, 15, 1'b0);
    ack_mode = 1;
    start_task(1, 1, 16'h0001);
    check("err_cleared", 32'(err), 0);
    wait_done();
    finish_task(49, 1, 0, 1'b0);
`else
    check("err_tied", 32'(err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
